// File: rtl/traj_pkg.sv
// Shared definitions for the trajectory stepper: FSM states and register field layout.
package traj_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_DONE
  } traj_state_e;

  // reg29 status layout
  localparam int unsigned R29_VALID_BIT = 0;
  localparam int unsigned R29_OVF_BIT   = 1;
  localparam int unsigned R29_HIT_BIT   = 2;
  localparam int unsigned R29_BUSY_BIT  = 3;
  localparam int unsigned R29_STEPS_LSB = 8;
  localparam int unsigned R29_STEPS_MSB = 23;
  localparam int unsigned R29_TAG_LSB   = 24;
  localparam int unsigned R29_TAG_MSB   = 31;

  // reg26 command layout
  localparam int unsigned R26_N_LSB   = 0;
  localparam int unsigned R26_N_MSB   = 15;
  localparam int unsigned R26_TAG_LSB = 24;
  localparam int unsigned R26_TAG_MSB = 31;

endpackage

// File: rtl/trajectory_stepper_if.sv
// Shared register window between the register file (master) and the stepper (slave).
interface trajectory_stepper_if;
  logic [31:0] reg20;
  logic [31:0] reg21;
  logic [31:0] reg22;
  logic [31:0] reg23;
  logic [31:0] reg24;
  logic [31:0] reg25;
  logic [31:0] reg26;
  logic [31:0] reg27;
  logic [31:0] reg28;
  logic [31:0] reg29;

  modport master (
    output reg20, reg21, reg22, reg23, reg24, reg25, reg26,
    input  reg27, reg28, reg29
  );

  modport slave (
    input  reg20, reg21, reg22, reg23, reg24, reg25, reg26,
    output reg27, reg28, reg29
  );
endinterface

// File: rtl/traj_add32.sv
// 32-bit wrapping signed adder; overflow flag is live only with TRAJ_OVERFLOW_DET_EN.
module traj_add32 (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] sum,
  output logic               ovf
);

  assign sum = a + b;

`ifdef TRAJ_OVERFLOW_DET_EN
  assign ovf = (a[31] == b[31]) && (sum[31] != a[31]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/trajectory_stepper.sv
// Euler projectile integrator on the shared register window (one step per cycle).
// Optional signed-overflow termination: TRAJ_OVERFLOW_DET_EN.
module trajectory_stepper
  import traj_pkg::*;
#(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned TAG_W  = 8
) (
  input logic                 clock,
  input logic                 ctrl_reset,
  trajectory_stepper_if.slave regs
);

  traj_state_e state, state_next;

  logic [TAG_W-1:0]  cmd_tag, cur_tag, out_tag;
  logic [STEP_W-1:0] cmd_n, n_steps, count, out_steps;
  logic signed [31:0] x, y, vx, vy, ay, g;
  logic signed [31:0] sum_x, sum_y, sum_vy;
  logic signed [31:0] out_x, out_y;
  logic ovf_x, ovf_y, ovf_vy, step_ovf;
  logic tag_changed, y_below, last_step;
  logic hit, out_hit, out_ovf, out_valid;
  logic unused_cmd_bits;
  logic [31:0] status;

  assign cmd_tag         = TAG_W'(regs.reg26[R26_TAG_MSB:R26_TAG_LSB]);
  assign cmd_n           = STEP_W'(regs.reg26[R26_N_MSB:R26_N_LSB]);
  assign unused_cmd_bits = ^regs.reg26[R26_TAG_LSB-1:R26_N_MSB+1];

  traj_add32 u_add_x  (.a(x),  .b(vx), .sum(sum_x),  .ovf(ovf_x));
  traj_add32 u_add_y  (.a(y),  .b(vy), .sum(sum_y),  .ovf(ovf_y));
  traj_add32 u_add_vy (.a(vy), .b(ay), .sum(sum_vy), .ovf(ovf_vy));

  assign tag_changed = (cmd_tag != cur_tag);
  assign y_below     = (sum_y < g);
  assign last_step   = ((count + STEP_W'(1)) == n_steps);
  assign step_ovf    = ovf_x | ovf_y | ovf_vy;

  always_ff @(posedge clock) begin
    if (ctrl_reset) state <= S_IDLE;
    else            state <= state_next;
  end

  // A tag change during STEP takes priority over every stop condition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (tag_changed) state_next = S_LOAD;
      S_LOAD: state_next = (cmd_n == '0) ? S_DONE : S_STEP;
      S_STEP: begin
        if (tag_changed)                         state_next = S_LOAD;
        else if (y_below || last_step || step_ovf) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef TRAJ_OVERFLOW_DET_EN
  logic ovf;
`else
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      x         <= '0;
      y         <= '0;
      vx        <= '0;
      vy        <= '0;
      ay        <= '0;
      g         <= '0;
      n_steps   <= '0;
      count     <= '0;
      cur_tag   <= '0;
      hit       <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_tag   <= '0;
      out_steps <= '0;
      out_hit   <= 1'b0;
      out_valid <= 1'b0;
`ifdef TRAJ_OVERFLOW_DET_EN
      ovf       <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          x       <= signed'(regs.reg25);
          y       <= signed'(regs.reg24);
          vx      <= signed'(regs.reg23);
          vy      <= signed'(regs.reg22);
          ay      <= signed'(regs.reg21);
          g       <= signed'(regs.reg20);
          n_steps <= cmd_n;
          cur_tag <= cmd_tag;
          count   <= '0;
          hit     <= 1'b0;
`ifdef TRAJ_OVERFLOW_DET_EN
          ovf     <= 1'b0;
`endif
        end
        S_STEP: begin
          if (!tag_changed) begin
            x     <= sum_x;
            y     <= sum_y;
            vy    <= sum_vy;
            count <= count + STEP_W'(1);
            hit   <= y_below;
`ifdef TRAJ_OVERFLOW_DET_EN
            ovf   <= step_ovf;
`endif
          end
        end
        S_DONE: begin
          out_x     <= x;
          out_y     <= y;
          out_tag   <= cur_tag;
          out_steps <= count;
          out_hit   <= hit;
          out_valid <= 1'b1;
`ifdef TRAJ_OVERFLOW_DET_EN
          out_ovf   <= ovf;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status = '0;
    status[R29_TAG_MSB:R29_TAG_LSB]     = 8'(out_tag);
    status[R29_STEPS_MSB:R29_STEPS_LSB] = 16'(out_steps);
    status[R29_BUSY_BIT]                = (state != S_IDLE);
    status[R29_HIT_BIT]                 = out_hit;
    status[R29_OVF_BIT]                 = out_ovf;
    status[R29_VALID_BIT]               = out_valid;
  end

  assign regs.reg27 = out_x;
  assign regs.reg28 = out_y;
  assign regs.reg29 = status;

endmodule

// File: tb/tb_trajectory_stepper.sv
// Scoreboard bench for trajectory_stepper: directed test-plan runs plus random runs vs. a reference model.
module tb_trajectory_stepper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trajectory_stepper_if bus();

  trajectory_stepper #(.STEP_W(16), .TAG_W(8)) dut (
    .clock      (clk),
    .ctrl_reset (rst),
    .regs       (bus)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] st;
    int          wcyc;
    int          lat;
    int          blen;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [7:0] last_tag = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: straightforward per-step integration with wide arithmetic for overflow.
  task automatic model(input int x0, input int y0, input int vx, input int vy0, input int ay,
                       input int g, input int n, output int xo, output int yo,
                       output int steps, output bit hit, output bit ovf);
    int x, y, vy;
    longint ex, ey, ev;
    x = x0; y = y0; vy = vy0;
    hit = 1'b0; ovf = 1'b0; steps = 0;
    for (int k = 0; k < n; k++) begin
      ex = longint'(x) + longint'(vx);
      ey = longint'(y) + longint'(vy);
      ev = longint'(vy) + longint'(ay);
      x = int'(ex);
      y = int'(ey);
      vy = int'(ev);
      steps++;
      if (y < g) hit = 1'b1;
`ifdef TRAJ_OVERFLOW_DET_EN
      if (ex != longint'(x) || ey != longint'(y) || ev != longint'(vy)) ovf = 1'b1;
`endif
      if (hit || ovf) break;
    end
    xo = x;
    yo = y;
  endtask

  function automatic logic [31:0] mk_status(input logic [7:0] tag, input int steps,
                                            input bit hit, input bit ovf);
    return {tag, 16'(steps), 4'b0000, 1'b0, hit, ovf, 1'b1};
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic set_regs(input logic [7:0] tag, input int x0, input int y0, input int vx,
                          input int vy0, input int ay, input int g, input int n);
    bus.reg25 = x0;
    bus.reg24 = y0;
    bus.reg23 = vx;
    bus.reg22 = vy0;
    bus.reg21 = ay;
    bus.reg20 = g;
    bus.reg26 = {tag, 8'h00, 16'(n)};
  endtask

  task automatic run(input logic [7:0] tag, input int x0, input int y0, input int vx,
                     input int vy0, input int ay, input int g, input int n);
    int xo, yo, steps;
    bit hit, ovf;
    exp_t e;
    model(x0, y0, vx, vy0, ay, g, n, xo, yo, steps, hit, ovf);
    @(posedge clk); #1;
    set_regs(tag, x0, y0, vx, vy0, ay, g, n);
    e.x = xo; e.y = yo; e.st = mk_status(tag, steps, hit, ovf);
    e.wcyc = cyc; e.lat = steps + 3; e.blen = steps + 2;
    sb.push_back(e);
    last_tag = tag;
    wait_drain();
  endtask

  // Monitor: a result is presented when busy falls.
  bit   prev_busy = 1'b0;
  int   blen = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (prev_busy && bus.reg29[3] === 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_publish: got reg29=0x%08h expected no output", bus.reg29);
      end else begin
        mon_e = sb.pop_front();
        check("reg27_x", bus.reg27, mon_e.x);
        check("reg28_y", bus.reg28, mon_e.y);
        check("reg29_status", bus.reg29, mon_e.st);
        if (mon_e.lat >= 0) check("latency", 32'(cyc - mon_e.wcyc), 32'(mon_e.lat));
        if (mon_e.blen >= 0) check("busy_len", 32'(blen), 32'(mon_e.blen));
      end
      blen = 0;
    end
    if (bus.reg29[3] === 1'b1) blen++;
    prev_busy = (bus.reg29[3] === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t;
    int mode, x0, y0, vx, vy0, ay, g, n, xo, yo, steps;
    bit hit, ovf;
    exp_t e;

    set_regs(8'h00, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_reg27", bus.reg27, 32'h0);
    check("reset_reg28", bus.reg28, 32'h0);
    check("reset_reg29", bus.reg29, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_tag0_reg29", bus.reg29, 32'h0);

    run(8'h01, 0, 100, 2, 10, -1, -1000, 5);
    run(8'h02, 0, 10, 0, 0, -2, 0, 100);
    run(8'h03, 7, 9, 0, 0, 0, 0, 0);

    // Abort: long run, then a new command three STEP cycles in.
    @(posedge clk); #1;
    set_regs(8'h04, 0, 0, 1, 0, 0, -10, 1000);
    repeat (5) @(posedge clk);
    #1;
    model(0, 0, 1, 0, 0, -10, 2, xo, yo, steps, hit, ovf);
    set_regs(8'h05, 0, 0, 1, 0, 0, -10, 2);
    e.x = xo; e.y = yo; e.st = mk_status(8'h05, steps, hit, ovf);
    e.wcyc = cyc; e.lat = steps + 3; e.blen = -1;
    sb.push_back(e);
    last_tag = 8'h05;
    wait_drain();

    run(8'h06, 32'h7FFFFFFF, 0, 1, 0, 0, -1, 10);

    // Reset mid-STEP with tag returned to 0: outputs clear and no restart.
    @(posedge clk); #1;
    set_regs(8'h10, 0, 0, 1, 0, 0, -10, 50);
    repeat (4) @(posedge clk);
    #1;
    e.x = '0; e.y = '0; e.st = '0; e.wcyc = cyc; e.lat = -1; e.blen = -1;
    sb.push_back(e);
    rst = 1'b1;
    bus.reg26 = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_restart_reg29", bus.reg29, 32'h0);
    last_tag = 8'h00;
    wait_drain();

    for (int r = 0; r < 25; r++) begin
      do t = 8'($urandom_range(1, 255)); while (t == last_tag);
      mode = int'($urandom_range(0, 3));
      if (mode == 3) begin
        x0 = int'($urandom); y0 = int'($urandom); vx = int'($urandom);
        vy0 = int'($urandom); ay = int'($urandom); g = int'($urandom);
        n = int'($urandom_range(0, 10));
      end else begin
        x0  = int'($urandom_range(0, 2000)) - 1000;
        y0  = int'($urandom_range(0, 5000));
        vx  = int'($urandom_range(0, 100)) - 50;
        vy0 = int'($urandom_range(0, 200)) - 100;
        ay  = -int'($urandom_range(0, 20));
        g   = y0 - int'($urandom_range(0, 3000));
        n   = int'($urandom_range(0, 40));
      end
      run(t, x0, y0, vx, vy0, ay, g, n);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trajectory_stepper.md
# trajectory_stepper

Fixed-point projectile integrator on the calculation side of the shared register window. Consumes the processor-written shared registers reg20–reg26 that the register file exports. Steps position and velocity one Euler step per cycle. Drives reg27–reg29, which the register file reloads every cycle, so software polls results with ordinary register reads.

## Interface
Parameters:
- STEP_W, 16, width of step-count field and step counter
- TAG_W, 8, width of command sequence tag

Ports (clock is `clock`; reset is `ctrl_reset`, synchronous, active-high):
- clock  in  1  sole clock
- ctrl_reset  in  1  synchronous active-high reset
- reg26  in  32  command: [31:24] tag, [15:0] step count N
- reg25  in  32  x0, signed
- reg24  in  32  y0, signed
- reg23  in  32  vx, signed
- reg22  in  32  vy0, signed
- reg21  in  32  ay (gravity), signed
- reg20  in  32  ground threshold g, signed
- reg27  out  32  published x
- reg28  out  32  published y
- reg29  out  32  status: [31:24] done_tag, [23:8] steps_done, [7:4] 0, [3] busy, [2] ground_hit, [1] overflow, [0] done_valid

## Operation
- States: IDLE, LOAD, STEP, DONE.
- Internal cur_tag holds the tag accepted at the last LOAD; reset value 0.
- IDLE: if reg26[31:24] != cur_tag, go to LOAD. Otherwise stay.
- LOAD: latch x, y, vx, vy, ay, g, and N; set cur_tag to the tag; clear count. If N==0, go to DONE; otherwise go to STEP.
- STEP, one step per cycle:
  - x += vx; y += vy; vy += ay (uses old vy); count += 1.
  - Stop to DONE if new y < g (signed), setting hit.
  - Stop to DONE if count+1 == N.
  - If both stop conditions hold, go to DONE with hit=1.
- STEP abort: if reg26 tag != cur_tag, discard the step and go to LOAD. Nothing is published.
- DONE: register reg27=x, reg28=y, and reg29 {cur_tag, count, hit, ovf, done_valid=1}. Return to IDLE.
- busy (reg29[3]) is live: 1 in LOAD/STEP/DONE, 0 in IDLE.
- All other reg29 fields change only on DONE.
- Arithmetic: 32-bit two's complement, wrap-around. count never exceeds N.
- Reset: in any state, returns to IDLE. All outputs 0; cur_tag=0. A tag of 0 after reset does not start a run.

## Timing
- Tag change sampled in IDLE at cycle 0; LOAD at cycle 1.
- STEP cycles 2..K+1 for K steps taken.
- DONE at cycle K+2; outputs updated at the clock edge ending DONE.
- The register file captures the outputs one edge later. Software sees results K+4 edges after the tag-changing write.
- N==0: DONE at cycle 2; outputs keep x0/y0 latched from LOAD and steps_done=0.
- Back-to-back: a new tag present while in DONE starts LOAD two cycles after DONE (through one IDLE cycle).

## Configuration
- `TRAJ_OVERFLOW_DET_EN` defined:
  - Signed overflow on any of the three adders in a STEP sets ovf.
  - Overflow terminates to DONE after that step; the step counts.
  - Wrapped values are published.
- Not defined: overflow wraps silently, reg29[1] is constant 0, and no overflow logic is synthesized.

## Structure
- Package traj_pkg holds:
  - state encoding
  - reg29 bit positions and field slices
  - reg26 tag/N field slices
- Sub-module traj_add32, instantiated three times: 32-bit signed adder with overflow flag output. The flag is tied 0 when the macro is off.

## Test plan
- Basic run: x0=0, y0=100, vx=2, vy=10, ay=-1, g=-1000, N=5, tag=0x01 -> reg27=10, reg28=140, steps_done=5, hit=0, done_tag=0x01, done_valid=1; result visible 9 edges after write.
- Ground hit: y0=10, vy=0, ay=-2, g=0, N=100, tag=0x02 -> reg28=-2, steps_done=4, hit=1.
- Zero steps: N=0, x0=7, y0=9, tag=0x03 -> reg27=7, reg28=9, steps_done=0; busy high exactly 2 cycles.
- Abort: start tag=0x04 with N=1000; after 3 STEP cycles write tag=0x05 with N=2 -> only the tag-0x05 result is published, steps_done=2, done_tag=0x05.
- Overflow: x0=0x7FFFFFFF, vx=1, N=10 -> with macro: reg27=0x80000000, steps_done=1, ovf=1; without macro: 10 steps, reg27=0x80000009, ovf=0.
- Reset mid-STEP: assert ctrl_reset one cycle during a run -> next cycle all outputs 0, busy=0, and no restart until the tag differs from 0.
